// File: rtl/md_issue_ctrl.sv
// Issue controller between the DX stage and a multi-cycle multdiv unit.
// Latches operands, pulses a start, waits for a result or times out.
module md_issue_ctrl #(
  parameter int TIMEOUT = 63,
  parameter int CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_mul,
  input  logic        issue_div,
  input  logic        flush,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  dest_reg,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_exception,
  output logic        illegal_issue
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [4:0]       dst_q, dst_d;
  logic             mul_q, mul_d;
  logic [31:0]      wbd_q, wbd_d;
  logic [4:0]       wbr_q, wbr_d;
  logic             wbe_q, wbe_d;

  logic go;
  logic stall_c, mul_c, div_c;
  logic valid_c, ill_c;

  assign go = (issue_mul ^ issue_div) & ~flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    dst_d   = dst_q;
    mul_d   = mul_q;
    wbd_d   = wbd_q;
    wbr_d   = wbr_q;
    wbe_d   = wbe_q;
    stall_c = 1'b0;
    mul_c   = 1'b0;
    div_c   = 1'b0;
    valid_c = 1'b0;
    ill_c   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stall_c = go;
        ill_c   = issue_mul & issue_div;
        if (go) begin
          a_d     = op_a;
          b_d     = op_b;
          dst_d   = dest_reg;
          mul_d   = issue_mul;
          state_d = S_START;
        end
      end
      S_START: begin
        stall_c = 1'b1;
        mul_c   = mul_q;
        div_c   = ~mul_q;
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        stall_c = 1'b1;
        if (md_resultRDY) begin
          wbd_d   = md_result;
          wbe_d   = md_exception;
          wbr_d   = dst_q;
          state_d = S_DONE;
        end else if (cnt_q == TMO) begin
          // No answer from the unit: retire as a faulting zero result.
          wbd_d   = '0;
          wbe_d   = 1'b1;
          wbr_d   = dst_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        valid_c = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dst_q   <= '0;
      mul_q   <= 1'b0;
      wbd_q   <= '0;
      wbr_q   <= '0;
      wbe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dst_q   <= dst_d;
      mul_q   <= mul_d;
      wbd_q   <= wbd_d;
      wbr_q   <= wbr_d;
      wbe_q   <= wbe_d;
    end
  end

  // Pulses are masked so an in-flight op aborts silently under reset.
  assign stall         = stall_c & ~reset;
  assign md_ctrl_mult  = mul_c & ~reset;
  assign md_ctrl_div   = div_c & ~reset;
  assign wb_valid      = valid_c & ~reset;
  assign illegal_issue = ill_c & ~reset;
  assign busy          = (state_q != S_IDLE);
  assign md_a          = a_q;
  assign md_b          = b_q;
  assign wb_data       = wbd_q;
  assign wb_reg        = wbr_q;
  assign wb_exception  = wbe_q;

endmodule
